// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants, state encoding and frame mask helper
package spi_pkg;

    localparam int MAXBITS = 32;
    localparam int BITS_W  = 6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Right-aligned mask of n ones; n=MAXBITS yields all ones.
    function automatic logic [MAXBITS-1:0] frame_mask(input logic [BITS_W-1:0] n);
        logic [2*MAXBITS-1:0] m;
        m = ({{(2*MAXBITS-1){1'b0}}, 1'b1} << n) - {{(2*MAXBITS-1){1'b0}}, 1'b1};
        return m[MAXBITS-1:0];
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for one asynchronous input
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI mode-0 slave, MSB first, 1..32 bit frames
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAXBITS     = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sck,
    input  logic               cs_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic               wr,
    input  logic [MAXBITS-1:0] din,
    input  logic [BITS_W-1:0]  bits,
    output logic [MAXBITS-1:0] dout,
    output logic               rx_ready,
    input  logic               rd,
    output logic               overrun,
    output logic               busy
);

    logic sck_s, cs_s, mosi_s;
    logic sck_q, cs_q;
    logic rise_sck, fall_sck, fall_cs, rise_cs;

    state_e             state_q, state_d;
    logic [MAXBITS-1:0] hold_q, hold_d;
    logic [MAXBITS-1:0] txsh_q, txsh_d;
    logic [MAXBITS-1:0] rxsh_q, rxsh_d;
    logic [BITS_W-1:0]  rxcnt_q, rxcnt_d;
    logic [MAXBITS-1:0] dout_q, dout_d;
    logic               rx_ready_q, rx_ready_d;
    logic               overrun_q, overrun_d;

    logic [MAXBITS-1:0] rx_next;
    logic [BITS_W-1:0]  cnt_next;
    logic [MAXBITS-1:0] tx_aligned;
    logic               frame_done;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .d(sck), .q(sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rstn(rstn), .d(cs_n), .q(cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .d(mosi), .q(mosi_s)
    );

    assign rise_sck =  sck_s & ~sck_q;
    assign fall_sck = ~sck_s &  sck_q;
    assign fall_cs  = ~cs_s  &  cs_q;
    assign rise_cs  =  cs_s  & ~cs_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = wr ? din : hold_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        rxcnt_d    = rxcnt_q;
        dout_d     = dout_q;
        rx_ready_d = rx_ready_q;
        overrun_d  = overrun_q;
        frame_done = 1'b0;
        rx_next    = {rxsh_q[MAXBITS-2:0], mosi_s};
        cnt_next   = rxcnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (fall_cs) begin
                    state_d = ST_ACTIVE;
                    txsh_d  = hold_q;
                    rxcnt_d = '0;
                end
            end
            default: begin
                // CS rising takes priority over any SCK edge: partial frame is dropped.
                if (rise_cs) begin
                    state_d = ST_IDLE;
                end else begin
                    if (rise_sck) begin
                        rxsh_d  = rx_next;
                        rxcnt_d = cnt_next;
                        if ((bits != '0) && (cnt_next == bits)) begin
                            frame_done = 1'b1;
                            rxcnt_d    = '0;
                            dout_d     = rx_next & frame_mask(bits);
                        end
                    end
                    if (fall_sck) begin
                        txsh_d = (rxcnt_q == '0) ? hold_q : (txsh_q << 1);
                    end
                end
            end
        endcase

        if (frame_done) begin
            rx_ready_d = 1'b1;
            if (rx_ready_q && !rd) begin
                overrun_d = 1'b1;
            end
        end else if (rd) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rxcnt_q    <= '0;
            dout_q     <= '0;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sck_q      <= sck_s;
            cs_q       <= cs_s;
            state_q    <= state_d;
            hold_q     <= hold_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rxcnt_q    <= rxcnt_d;
            dout_q     <= dout_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        tx_aligned = txsh_q >> (bits - 1'b1);
        miso       = (state_q == ST_ACTIVE) && (bits != '0) ? tx_aligned[0] : 1'b0;
    end

    assign miso_oe  = (state_q == ST_ACTIVE);
    assign busy     = (state_q == ST_ACTIVE);
    assign dout     = dout_q;
    assign rx_ready = rx_ready_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave driven by a behavioural SPI master
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rstn, sck, cs_n, mosi, wr, rd;
    logic [31:0] din;
    logic [5:0]  bits;
    logic        miso, miso_oe, rx_ready, overrun, busy;
    logic [31:0] dout;

    spi_slave dut (
        .clk(clk), .rstn(rstn), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr(wr), .din(din), .bits(bits),
        .dout(dout), .rx_ready(rx_ready), .rd(rd), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the CPU side should observe.
    logic [31:0] m_hold, m_dout;
    logic        m_ready, m_ovr;

    typedef struct {
        int          nb;
        logic [31:0] tx;
        logic [31:0] mo;
        logic [31:0] exp_rx;
        logic [31:0] exp_dout;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [31:0] fmask(input int n);
        if (n >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << n) - 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [31:0] v);
        din = v;
        wr  = 1'b1;
        @(negedge clk);
        wr  = 1'b0;
        m_hold = v;
    endtask

    task automatic do_rd;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_frame(input int n, input logic [31:0] mo);
        m_ovr   = m_ovr | m_ready;
        m_ready = 1'b1;
        m_dout  = mo & fmask(n);
    endtask

    task automatic cs_low;
        cs_n = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_high;
        clk_wait(4);
        cs_n = 1'b1;
        clk_wait(6);
    endtask

    // SCK = Fclk/8: mosi changes while SCK low, miso sampled just before the rise.
    task automatic xfer(input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            clk_wait(4);
            rx = {rx[30:0], miso};
            sck = 1'b1;
            clk_wait(4);
            sck = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] mo, output logic [31:0] rx);
        bits = 6'(n);
        cs_low;
        xfer(n, mo, rx);
        cs_high;
        model_frame(n, mo);
    endtask

    initial begin
        logic [31:0] r1, r2, exp_rx;
        int          nb;
        logic [31:0] mo;

        vecs[0] = '{8,  32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C};
        vecs[1] = '{32, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2] = '{1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        vecs[3] = '{13, 32'h0000_1ABC, 32'h0000_0F0F, 32'h0000_1ABC, 32'h0000_0F0F};
        vecs[4] = '{13, 32'hFFFF_FABC, 32'hFFFF_1234, 32'h0000_1ABC, 32'h0000_1234};

        rstn = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        wr = 1'b0; rd = 1'b0; din = '0; bits = 6'd8;
        m_hold = '0; m_dout = '0; m_ready = 1'b0; m_ovr = 1'b0;

        clk_wait(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dout", dout, 32'd0);
        check("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rstn = 1'b1;
        clk_wait(4);

        for (int v = 0; v < 5; v++) begin
            do_wr(vecs[v].tx);
            frame(vecs[v].nb, vecs[v].mo, r1);
            check($sformatf("vec%0d_master_rx", v), r1, vecs[v].exp_rx);
            check($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
            check($sformatf("vec%0d_rx_ready", v), {31'd0, rx_ready}, 32'd1);
            check($sformatf("vec%0d_overrun", v), {31'd0, overrun}, 32'd0);
            do_rd;
        end

        // Back-to-back frames under one CS, no rd in between; TX resent.
        do_wr(32'h5A);
        bits = 6'd8;
        cs_low;
        xfer(8, 32'h11, r1);
        xfer(8, 32'h22, r2);
        cs_high;
        model_frame(8, 32'h11);
        model_frame(8, 32'h22);
        check("b2b_rx1", r1, 32'h5A);
        check("b2b_rx2", r2, 32'h5A);
        check("b2b_dout", dout, 32'h22);
        check("b2b_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("b2b_overrun", {31'd0, overrun}, 32'd1);
        do_rd;
        check("b2b_rd_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("b2b_rd_overrun", {31'd0, overrun}, 32'd0);

        // Aborted frame after 5 of 8 rises leaves CPU-visible state alone.
        frame(8, 32'h77, r1);
        cs_low;
        xfer(5, 32'h1F, r1);
        cs_high;
        check("abort_dout", dout, 32'h77);
        check("abort_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
        do_rd;
        do_wr(32'hC3);
        frame(8, 32'h96, r1);
        check("post_abort_rx", r1, 32'hC3);
        check("post_abort_dout", dout, 32'h96);
        check("post_abort_overrun", {31'd0, overrun}, 32'd0);
        do_rd;

        // wr mid-frame only affects the following frame.
        do_wr(32'hAA);
        bits = 6'd8;
        cs_low;
        xfer(4, 32'h3, r1);
        do_wr(32'h55);
        xfer(4, 32'hC, r2);
        cs_high;
        model_frame(8, 32'h3C);
        check("midwr_cur_rx", {24'd0, r1[3:0], r2[3:0]}, 32'hAA);
        check("midwr_dout", dout, 32'h3C);
        frame(8, 32'h01, r1);
        check("midwr_next_rx", r1, 32'h55);
        do_rd;

        // Randomized frames against the model.
        for (int it = 0; it < 24; it++) begin
            nb = int'($urandom_range(1, 32));
            if ($urandom_range(0, 2) != 0) do_wr($urandom);
            mo = $urandom;
            exp_rx = m_hold & fmask(nb);
            frame(nb, mo, r1);
            check($sformatf("rnd%0d_rx", it), r1, exp_rx);
            check($sformatf("rnd%0d_dout", it), dout, m_dout);
            check($sformatf("rnd%0d_ready", it), {31'd0, rx_ready}, {31'd0, m_ready});
            check($sformatf("rnd%0d_ovr", it), {31'd0, overrun}, {31'd0, m_ovr});
            if ($urandom_range(0, 1) != 0) begin
                do_rd;
                check($sformatf("rnd%0d_rd_ready", it), {31'd0, rx_ready}, 32'd0);
                check($sformatf("rnd%0d_rd_ovr", it), {31'd0, overrun}, 32'd0);
            end
        end

        // Asynchronous reset mid-frame.
        frame(8, 32'hE7, r1);
        do_wr(32'hF0);
        bits = 6'd8;
        cs_low;
        xfer(3, 32'h7, r1);
        rstn = 1'b0;
        #1;
        check("rst_mid_miso", {31'd0, miso}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_mid_dout", dout, 32'd0);
        check("rst_mid_rx_ready", {31'd0, rx_ready}, 32'd0);
        cs_n = 1'b1;
        sck  = 1'b0;
        clk_wait(2);
        rstn = 1'b1;
        m_hold = '0; m_dout = '0; m_ready = 1'b0; m_ovr = 1'b0;
        clk_wait(4);
        do_wr(32'h3E);
        frame(8, 32'h81, r1);
        check("post_rst_rx", r1, 32'h3E);
        check("post_rst_dout", dout, 32'h81);
        check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 slave: the far end of our SPI master, for board-level loopback and for FPGA-as-peripheral use.
- Oversamples SCK, CS_N and MOSI in the system clock domain, then shifts MSB-first.
- Frame length is 1..32 bits, matching the master's bits field.
- Exposes a TX holding register, an RX data register with ready/overrun flags, and a busy flag to the CPU bus glue.

Parameters:
SYNC_STAGES, 2, synchronizer flops per async input (min 2)
MAXBITS, 32, maximum frame length; fixes shift register width

Ports:
clk  in  1  system clock; requires Fclk >= 8*Fsck
rstn  in  1  asynchronous reset, active low
sck  in  1  SPI clock from master (async)
cs_n  in  1  chip select, active low (async)
mosi  in  1  serial data from master (async)
miso  out  1  serial data to master
miso_oe  out  1  MISO output enable (1 while selected)
wr  in  1  one-cycle strobe: load din into TX holding register
din  in  32  TX data; only LSBs [bits-1:0] are used
bits  in  6  frame length 1..32; static while cs_n low
dout  out  32  last received frame, right-aligned, upper bits zero
rx_ready  out  1  dout holds unread data
rd  in  1  one-cycle strobe: CPU has read dout; clears rx_ready and overrun
overrun  out  1  sticky: a frame completed while rx_ready=1
busy  out  1  cs_n (synchronized) low

Behaviour:
- Reset (rstn=0, async): all state cleared; miso=0, miso_oe=0, dout=0, rx_ready=0, overrun=0, busy=0, TX holding=0, state IDLE.
- Sync: sck, cs_n and mosi each pass SYNC_STAGES flops, plus one extra flop on sck and cs_n for edge detection.
  - Edges (rise_sck, fall_sck, fall_cs, rise_cs) are single-cycle pulses, valid SYNC_STAGES+1 clk after the pin edge.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on fall_cs: txsh <= TX holding; rxcnt <= 0.
  - ACTIVE -> IDLE on rise_cs from any point; a partial frame is discarded (no rx_ready, no dout change).
  - SCK edges in IDLE are ignored.
- busy = miso_oe = (state==ACTIVE).
- miso = txsh[bits-1] when ACTIVE, else 0.
  - First bit is valid SYNC_STAGES+1 clk after the CS_N fall; master setup margin is covered by the Fclk >= 8*Fsck rule.
- RX, ACTIVE on rise_sck: rxsh <= {rxsh[30:0], mosi_sync}; rxcnt++.
  - When rxcnt reaches bits, the frame completes in that same cycle: dout <= new rxsh masked to bits; rxcnt <= 0.
  - On completion: if rx_ready=1 then overrun <= 1 (dout is still overwritten); rx_ready <= 1.
- TX, ACTIVE on fall_sck:
  - Normally txsh shifts left by one.
  - If rxcnt==0 (a frame has just completed), txsh reloads from TX holding instead. Back-to-back frames under one CS_N are supported.
- wr: TX holding <= din in any state. The value takes effect at the next frame start or reload, never mid-frame.
  - If no wr occurs between frames, the same data is resent.
- rd: clears rx_ready and overrun next cycle.
  - rd in the same cycle as a frame completion: completion wins; rx_ready=1, overrun unchanged.
- bits=0 is illegal: no frame ever completes; miso=0.
- Simultaneous rise_sck and rise_cs: rise_cs wins; frame discarded.
- Reset mid-frame: immediate return to IDLE, outputs at reset values; the master sees miso=0.

Decomposition:
- Shared package spi_pkg holds:
  - MAXBITS=32 and BITS_W=6, also used by the master;
  - state encoding localparams ST_IDLE and ST_ACTIVE.
- One natural sub-module: sync_ff (SYNC_STAGES-deep synchronizer, async active-low reset, reset value parameterized).
  - Instantiated per input; reset value 1 for cs_n and 0 for sck and mosi.

Test Plan:
- Reset, then wr din=0xA5, bits=8; master sends 0x3C at Fsck=Fclk/8 -> master receives 0xA5; dout=0x0000003C; rx_ready=1; overrun=0.
- bits=32, TX=0xDEADBEEF, master sends 0x12345678 -> dout=0x12345678; master gets 0xDEADBEEF. Repeat with bits=1 and bits=13 (TX=0x1ABC -> low 13 bits 0x1ABC).
- Two 8-bit frames 0x11, 0x22 under one CS_N, no rd between -> dout=0x22, rx_ready=1, overrun=1; then rd -> both flags 0 on the next cycle.
- CS_N deasserted after 5 of 8 SCK rises -> dout unchanged, rx_ready unchanged, busy=0, miso_oe=0; the next full frame is received correctly.
- wr din=0x55 mid-frame while sending 0xAA -> the current frame still transmits 0xAA; the next frame transmits 0x55.
- rstn pulsed low mid-frame -> miso=0, busy=0, dout=0 immediately (no clk edge needed); a subsequent frame works normally.
